// File: rtl/seq_encoder_pkg.sv
// Shared constants and state encoding for the sequential 32-to-5 encoder.
package seq_encoder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_IDX_W = 5;

   // 2'd3 is unused and recovers to IDLE
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_encoder_if.sv
// Load/emit handshake bundle between a mask producer and the encoder.
interface seq_encoder_if
   import seq_encoder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDX_W = $clog2(WIDTH)
);

   logic             iEna;
   logic             iLoad;
   logic [WIDTH-1:0] iData;
   logic             iReady;
   logic             oValid;
   logic [IDX_W-1:0] oData;
   logic             oBusy;
   logic             oDone;
   logic [IDX_W:0]   oCount;

   modport master (
      output iEna, iLoad, iData, iReady,
      input  oValid, oData, oBusy, oDone, oCount
   );

   modport slave (
      input  iEna, iLoad, iData, iReady,
      output oValid, oData, oBusy, oDone, oCount
   );

endinterface

// File: rtl/prio_enc32.sv
// Combinational lowest-set-bit encoder; idx is 0 for an all-zero vector.
module prio_enc32
   import seq_encoder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vector,
   output logic [IDX_W-1:0] idx,
   output logic             zero
);

   // Scan from the top so the lowest set bit wins
   always_comb begin
      idx  = '0;
      zero = ~|vector;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vector[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/seq_encoder.sv
// Sequential multi-hot to index encoder: emits each set bit, lowest first,
// one index per valid/ready handshake.
module seq_encoder
   import seq_encoder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input logic          clk,
   input logic          rst,
   seq_encoder_if.slave bus
);

   state_t           state, stateNext;
   logic [WIDTH-1:0] pending, pendingNext;
   logic [WIDTH-1:0] cleared;
   logic [IDX_W-1:0] data, dataNext;
   logic [IDX_W:0]   count, countNext;
   logic [IDX_W-1:0] loadIdx, advIdx;
   logic             loadZero, advZero;

   prio_enc32 #(.WIDTH(WIDTH), .IDX_W(IDX_W)) uLoadEnc (
      .vector (bus.iData),
      .idx    (loadIdx),
      .zero   (loadZero)
   );

   prio_enc32 #(.WIDTH(WIDTH), .IDX_W(IDX_W)) uAdvEnc (
      .vector (cleared),
      .idx    (advIdx),
      .zero   (advZero)
   );

   always_comb begin
      cleared       = pending;
      cleared[data] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pending <= '0;
         data    <= '0;
         count   <= '0;
      end else begin
         state   <= stateNext;
         pending <= pendingNext;
         data    <= dataNext;
         count   <= countNext;
      end
   end

   always_comb begin
      stateNext   = state;
      pendingNext = pending;
      dataNext    = data;
      countNext   = count;
      if (bus.iEna) begin
         unique case (state)
            IDLE: begin
               if (bus.iLoad) begin
                  pendingNext = bus.iData;
                  countNext   = '0;
                  if (loadZero) begin
                     stateNext = DONE;
                  end else begin
                     dataNext  = loadIdx;
                     stateNext = EMIT;
                  end
               end
            end
            EMIT: begin
               if (bus.iReady) begin
                  pendingNext = cleared;
                  countNext   = count + {{IDX_W{1'b0}}, 1'b1};
                  dataNext    = advIdx;
                  if (advZero) stateNext = DONE;
               end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
         endcase
      end
   end

   // Pure decodes of registered state: no input-to-output paths
   assign bus.oValid = (state == EMIT);
   assign bus.oBusy  = (state != IDLE);
   assign bus.oDone  = (state == DONE);
   assign bus.oData  = data;
   assign bus.oCount = count;

endmodule

// File: tb/tb_seq_encoder.sv
// Self-checking bench for seq_encoder: queue-based reference model plus
// directed scenarios and randomized loads.
module tb_seq_encoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   seq_encoder_if bus ();

   seq_encoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: expected indices as a queue, phase 0 idle/1 scan/2 done
   int mQ[$];
   int mPhase = 0;
   int mCnt = 0;
   int got[$];

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mQ.delete();
         mPhase = 0;
         mCnt = 0;
      end else if (bus.iEna) begin
         case (mPhase)
            0: if (bus.iLoad) begin
               mCnt = 0;
               mQ.delete();
               for (int i = 0; i < 32; i++)
                  if (bus.iData[i]) mQ.push_back(i);
               mPhase = (mQ.size() != 0) ? 1 : 2;
            end
            1: if (bus.iReady) begin
               void'(mQ.pop_front());
               mCnt++;
               if (mQ.size() == 0) mPhase = 2;
            end
            default: mPhase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rstValid", int'(bus.oValid), 0);
         chk("rstBusy", int'(bus.oBusy), 0);
         chk("rstDone", int'(bus.oDone), 0);
         chk("rstCount", int'(bus.oCount), 0);
      end else begin
         chk("valid", int'(bus.oValid), int'(mPhase == 1));
         chk("busy", int'(bus.oBusy), int'(mPhase != 0));
         chk("done", int'(bus.oDone), int'(mPhase == 2));
         chk("count", int'(bus.oCount), mCnt);
         if (bus.oValid && mQ.size() != 0)
            chk("data", int'(bus.oData), mQ[0]);
         if (bus.oValid && bus.iReady && bus.iEna)
            got.push_back(int'(bus.oData));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(logic [31:0] d);
      got.delete();
      bus.iEna  = 1'b1;
      bus.iLoad = 1'b1;
      bus.iData = d;
      tick();
      bus.iLoad = 1'b0;
   endtask

   task automatic waitIdle();
      for (int n = 0; n < 400 && bus.oBusy; n++) tick();
      chk("idleTimeout", int'(bus.oBusy), 0);
   endtask

   task automatic chkSeq(string nm, int exp[$]);
      chk({nm, "Len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         if (i < got.size()) chk({nm, "Idx"}, got[i], exp[i]);
   endtask

   initial begin
      int exp[$];
      logic [31:0] d;
      bus.iEna   = 1'b1;
      bus.iLoad  = 1'b0;
      bus.iData  = '0;
      bus.iReady = 1'b0;
      #1;
      chk("resetBusy", int'(bus.oBusy), 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Idle: data without load must not start a scan
      bus.iData = 32'hFFFF_FFFF;
      repeat (3) tick();
      chk("noLoadBusy", int'(bus.oBusy), 0);

      // Basic scan
      bus.iReady = 1'b1;
      load(32'h8000_0015);
      chk("firstValid", int'(bus.oValid), 1);
      chk("firstData", int'(bus.oData), 0);
      waitIdle();
      exp = {0, 2, 4, 31};
      chkSeq("basic", exp);
      chk("basicCount", int'(bus.oCount), 4);

      // Backpressure
      bus.iReady = 1'b0;
      load(32'h0000_0300);
      bus.iReady = 1'b0; tick();
      chk("bpHold", int'(bus.oData), 8);
      bus.iReady = 1'b1; tick();
      bus.iReady = 1'b0; tick();
      chk("bpHold2", int'(bus.oData), 9);
      bus.iReady = 1'b0; tick();
      bus.iReady = 1'b1; tick();
      waitIdle();
      exp = {8, 9};
      chkSeq("bp", exp);
      chk("bpCount", int'(bus.oCount), 2);

      // Empty load
      load(32'h0);
      chk("emptyDone", int'(bus.oDone), 1);
      chk("emptyValid", int'(bus.oValid), 0);
      tick();
      chk("emptyDoneOff", int'(bus.oDone), 0);
      chk("emptyCount", int'(bus.oCount), 0);

      // Full vector with an ignored mid-scan load
      load(32'hFFFF_FFFF);
      repeat (4) tick();
      bus.iLoad = 1'b1;
      bus.iData = 32'h1;
      tick();
      bus.iLoad = 1'b0;
      waitIdle();
      exp.delete();
      for (int i = 0; i < 32; i++) exp.push_back(i);
      chkSeq("full", exp);
      chk("fullCount", int'(bus.oCount), 32);

      // Enable dropped after index 5
      load(32'h0000_00F0);
      tick();
      tick();
      bus.iEna = 1'b0;
      repeat (3) begin
         tick();
         chk("frozenData", int'(bus.oData), 6);
         chk("frozenValid", int'(bus.oValid), 1);
      end
      bus.iEna = 1'b1;
      waitIdle();
      exp = {4, 5, 6, 7};
      chkSeq("ena", exp);

      // Reset after index 5
      load(32'h0000_00F0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("midRstValid", int'(bus.oValid), 0);
      chk("midRstCount", int'(bus.oCount), 0);
      chk("midRstBusy", int'(bus.oBusy), 0);
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("postRstValid", int'(bus.oValid), 0);

      // Randomized loads, readiness and enable
      for (int t = 0; t < 30; t++) begin
         case ($urandom % 4)
            0: d = $urandom;
            1: d = $urandom & $urandom & $urandom;
            2: d = 32'h1 << ($urandom % 32);
            default: d = '0;
         endcase
         bus.iReady = 1'($urandom % 2);
         load(d);
         for (int n = 0; n < 600 && bus.oBusy; n++) begin
            bus.iReady = 1'($urandom % 2);
            bus.iEna   = ($urandom % 8) != 0;
            tick();
         end
         bus.iEna = 1'b1;
         chk("randIdle", int'(bus.oBusy), 0);
         chk("randCount", int'(bus.oCount), $countones(d));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
